// File: rtl/load_store_unit.sv
// Load/store unit: turns one RV32I load/store request into word accesses on a
// data_memory that rewrites the addressed word on every edge. Sub-word stores
// are read-modify-write, word-crossing accesses are split into two words.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [31:0]           mem_read_data,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [31:0]           mem_write_data
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LANES   = 4;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned OFF_W   = 2;
  localparam int unsigned POS_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_next;

  // Captured request
  logic [OFF_W-1:0]      off_q;
  logic [SIZE_W-1:0]     size_q;
  logic                  sign_q;
  logic                  store_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  cross_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [DATA_W-1:0]     buf_q;

  // Combinational helpers
  logic                  accept_c;
  logic                  req_legal_c;
  logic [SIZE_W-1:0]     req_size_c;
  logic                  req_cross_c;
  logic [LANES-1:0]      lane_en_c;
  logic [OFF_W-1:0]      lane_idx_c [LANES];
  logic [DATA_W-1:0]     buf_next_c;
  logic [DATA_W-1:0]     load_ext_c;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  assign req_ready      = (state == IDLE);
  assign accept_c       = req_valid && (state == IDLE);
  assign mem_read_addr  = ptr_q;
  assign mem_write_addr = ptr_q;

  // Decode size, legality and word crossing of the incoming request
  always_comb begin
    req_size_c  = SIZE_W'(1);
    req_legal_c = 1'b0;
    case (req_funct3[1:0])
      2'b00:   req_size_c = SIZE_W'(1);
      2'b01:   req_size_c = SIZE_W'(2);
      default: req_size_c = SIZE_W'(4);
    endcase
    if (req_store) begin
      req_legal_c = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010);
    end else begin
      req_legal_c = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                    (req_funct3 == 3'b101);
    end
    req_cross_c = (SIZE_W'({1'b0, req_addr[1:0]}) + req_size_c) > SIZE_W'(4);
  end

  // Map each byte lane of the current word to its request byte index
  always_comb begin
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] idx;
    pos = '0;
    idx = '0;
    for (int j = 0; j < LANES; j++) begin
      pos = (state == ACC1) ? POS_W'(j + 4) : POS_W'(j);
      idx = pos - POS_W'({1'b0, off_q});
      lane_en_c[j]  = ((state == ACC0) || (state == ACC1)) && !err_q &&
                      (pos >= POS_W'({1'b0, off_q})) && (idx < size_q);
      lane_idx_c[j] = idx[OFF_W-1:0];
    end
  end

  // Store merge into the rewritten word, and load byte assembly
  always_comb begin
    mem_write_data = mem_read_data;
    buf_next_c     = buf_q;
    for (int j = 0; j < LANES; j++) begin
      if (lane_en_c[j]) begin
        if (store_q) begin
          mem_write_data[8*j +: 8] = wdata_q[{lane_idx_c[j], 3'b000} +: 8];
        end else begin
          buf_next_c[{lane_idx_c[j], 3'b000} +: 8] = mem_read_data[8*j +: 8];
        end
      end
    end
  end

  // Sign/zero extension of the assembled load value
  always_comb begin
    load_ext_c = buf_next_c;
    case (size_q)
      SIZE_W'(1): load_ext_c = sign_q ? {{24{buf_next_c[7]}}, buf_next_c[7:0]}
                                      : {24'd0, buf_next_c[7:0]};
      SIZE_W'(2): load_ext_c = sign_q ? {{16{buf_next_c[15]}}, buf_next_c[15:0]}
                                      : {16'd0, buf_next_c[15:0]};
      default:    load_ext_c = buf_next_c;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = ACC0;
      ACC0:    state_next = (cross_q && !err_q) ? ACC1 : RESP;
      ACC1:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Request capture, word pointer and load assembly buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q   <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      store_q <= 1'b0;
      wdata_q <= '0;
      cross_q <= 1'b0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      buf_q   <= '0;
    end else if (accept_c) begin
      off_q   <= req_addr[1:0];
      size_q  <= req_size_c;
      sign_q  <= !req_funct3[2];
      store_q <= req_store;
      wdata_q <= req_wdata;
      cross_q <= req_cross_c;
      err_q   <= !req_legal_c;
      ptr_q   <= req_addr[ADDR_WIDTH+1:2];
      buf_q   <= '0;
    end else begin
      if ((state == ACC0) && (state_next == ACC1)) ptr_q <= ptr_q + 1'b1;
      if ((state == ACC0) || (state == ACC1))      buf_q <= buf_next_c;
    end
  end

  // Response registers, one-cycle pulse entering RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= (state_next == RESP);
      resp_err   <= (state_next == RESP) && err_q;
      resp_rdata <= ((state_next == RESP) && !err_q && !store_q) ? load_ext_c : '0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural data_memory plus a byte-array
// reference model, directed scenarios followed by randomized requests.
module tb_load_store_unit;

  localparam int unsigned AW     = 12;
  localparam int unsigned WORDS  = 1 << AW;
  localparam int unsigned NBYTES = WORDS * 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_store;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_read_addr;
  logic [31:0]   mem_read_data;
  logic [AW-1:0] mem_write_addr;
  logic [31:0]   mem_write_data;

  logic [31:0] mem     [WORDS];
  logic [7:0]  ref_mem [NBYTES];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data)
  );

  // data_memory: combinational read, unconditional write every edge
  assign mem_read_data = mem[mem_read_addr];
  always @(posedge clk) mem[mem_write_addr] <= mem_write_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  // Reference: byte-addressed memory, byte i of the access at (addr+i) mod size
  function automatic void ref_op(input bit st, input bit [2:0] f3, input bit [31:0] a,
                                 input bit [31:0] wd, output bit [31:0] rd,
                                 output bit er, output int lat);
    int n;
    int b;
    bit legal;
    bit [31:0] v;
    legal = st ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                                 f3 == 3'd4 || f3 == 3'd5);
    n   = 1 << f3[1:0];
    rd  = 32'd0;
    er  = !legal;
    lat = 2;
    v   = 32'd0;
    if (!legal) return;
    if (int'(a[1:0]) + n > 4) lat = 3;
    for (int i = 0; i < n; i++) begin
      b = int'((a + 32'(i)) & 32'(NBYTES - 1));
      if (st) ref_mem[b] = wd[8*i +: 8];
      else    v[8*i +: 8] = ref_mem[b];
    end
    if (!st) begin
      case (n)
        1:       rd = f3[2] ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
        2:       rd = f3[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        default: rd = v;
      endcase
    end
  endfunction

  task automatic do_req(input bit st, input bit [2:0] f3, input bit [31:0] a,
                        input bit [31:0] wd, output logic [31:0] rd, output logic er);
    bit [31:0] exp_rd;
    bit        exp_er;
    int        exp_lat;
    int        lat;
    int        waited;
    @(negedge clk);
    waited = 0;
    while (!req_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_wdata = $urandom;
    ref_op(st, f3, a, wd, exp_rd, exp_er, exp_lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 8);
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_err", 32'(resp_err), 32'(exp_er));
    rd = resp_rdata;
    er = resp_err;
    @(negedge clk);
    check("resp_pulse_end", 32'(resp_valid), 32'd0);
    check("rdata_idle_zero", resp_rdata, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] old_w1;
    logic [31:0] v;
    int          bad;
    int          seen;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    for (int w = 0; w < WORDS; w++) begin
      v = $urandom;
      mem[w] = v;
      for (int k = 0; k < 4; k++) ref_mem[4*w+k] = v[8*k +: 8];
    end

    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_read_addr", 32'(mem_read_addr), 32'd0);
    check("rst_write_addr", 32'(mem_write_addr), 32'd0);
    check("rst_write_data", mem_write_data, mem[0]);
    @(negedge clk);
    rst = 1'b0;

    // Word store and load
    do_req(1'b1, 3'd2, 32'h010, 32'hDEADBEEF, rd, er);
    do_req(1'b0, 3'd2, 32'h010, 32'h0, rd, er);
    check("sw_lw", rd, 32'hDEADBEEF);

    // Byte store read back in several widths
    do_req(1'b1, 3'd0, 32'h013, 32'h000000AA, rd, er);
    do_req(1'b0, 3'd2, 32'h010, 32'h0, rd, er);
    check("sb_lw", rd, 32'hAAADBEEF);
    do_req(1'b0, 3'd0, 32'h013, 32'h0, rd, er);
    check("sb_lb", rd, 32'hFFFFFFAA);
    do_req(1'b0, 3'd4, 32'h013, 32'h0, rd, er);
    check("sb_lbu", rd, 32'h000000AA);
    do_req(1'b0, 3'd1, 32'h012, 32'h0, rd, er);
    check("sb_lh", rd, 32'hFFFFAAAD);

    // Word-crossing store and load
    do_req(1'b1, 3'd2, 32'h01C, 32'h0, rd, er);
    do_req(1'b1, 3'd2, 32'h020, 32'h0, rd, er);
    do_req(1'b1, 3'd2, 32'h01E, 32'h11223344, rd, er);
    check("cross_word0", mem[7], 32'h33440000);
    check("cross_word1", mem[8], 32'h00001122);
    do_req(1'b0, 3'd2, 32'h01E, 32'h0, rd, er);
    check("cross_lw", rd, 32'h11223344);

    // Wrap from the top word to word 0
    do_req(1'b1, 3'd0, 32'h3FFF, 32'h80, rd, er);
    do_req(1'b1, 3'd0, 32'h0000, 32'h7F, rd, er);
    do_req(1'b0, 3'd1, 32'h3FFF, 32'h0, rd, er);
    check("wrap_lh", rd, 32'h00007F80);

    // Idle integrity and illegal funct3
    do_req(1'b1, 3'd2, 32'h100, 32'hCAFEF00D, rd, er);
    repeat (20) @(negedge clk);
    do_req(1'b0, 3'd2, 32'h100, 32'h0, rd, er);
    check("idle_lw", rd, 32'hCAFEF00D);
    do_req(1'b1, 3'd3, 32'h100, 32'h12345678, rd, er);
    check("illegal_err", 32'(er), 32'd1);
    check("illegal_rdata", rd, 32'd0);
    do_req(1'b0, 3'd2, 32'h100, 32'h0, rd, er);
    check("illegal_untouched", rd, 32'hCAFEF00D);

    // Reset during ACC1 of a crossing word store
    old_w1 = mem[12];
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h02E;
    req_wdata  = 32'hA1B2C3D4;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("acc1_not_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    ref_mem[32'h2E] = 8'hD4;
    ref_mem[32'h2F] = 8'hC3;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("abort_no_resp", 32'(seen), 32'd0);
    check("abort_word0", mem[11], ref_word(11));
    check("abort_word1", mem[12], old_w1);
    do_req(1'b0, 3'd2, 32'h02C, 32'h0, rd, er);

    // Randomized requests, half of them in a small hot region
    for (int t = 0; t < 400; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rd, er);
    end

    bad = 0;
    for (int w = 0; w < WORDS; w++) if (mem[w] !== ref_word(w)) bad++;
    check("memory_image", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the execute stage and `data_memory`. It turns one RV32I load or store request (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses on the memory's plain 32-bit write port and combinational read port.

- Sub-word stores are done as read-modify-write.
- Accesses that cross a word boundary are split into two word accesses.
- Loads return a sign- or zero-extended result.

`data_memory` writes on every clock edge and has no write enable. This block therefore drives the memory so that every edge rewrites an existing word with its own contents unless a store is committing.

## Interface

Parameters:
- `ADDR_WIDTH`, default 12: word-address width of the attached `data_memory` (`2**ADDR_WIDTH` words).

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- `req_store`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RV32I funct3.
- `req_addr`  in  32: byte address; bits above `ADDR_WIDTH+1` are ignored.
- `req_wdata`  in  32: store data; the low byte/half is used for SB/SH.
- `resp_valid`  out  1: one-cycle pulse; no backpressure.
- `resp_rdata`  out  32: load result; 0 for stores and errors.
- `resp_err`  out  1: illegal funct3.
- `mem_read_addr`  out  `ADDR_WIDTH`: to `data_memory` `read_addr`.
- `mem_read_data`  in  32: from `data_memory` `read_data` (combinational).
- `mem_write_addr`  out  `ADDR_WIDTH`: to `data_memory` `write_addr`.
- `mem_write_data`  out  32: to `data_memory` `write_data`.

## Operation

- **Legal funct3 values.**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000, 001, 010.
  - Any other value is illegal: no memory change, response has `resp_err=1` and `resp_rdata=0`.
- **Address decode.**
  - Size is 1/2/4 bytes; offset = `addr[1:0]`; word0 = `addr[ADDR_WIDTH+1:2]`.
  - An access crosses a word when offset + size > 4.
  - word1 = word0 + 1, modulo `2**ADDR_WIDTH`, so the top word wraps to word 0.
- **Byte order:** little-endian. Request byte i maps to word0 byte (offset+i) when that is below 4; otherwise it maps to word1 byte (offset+i−4).
- **Registers captured on accept:** address, size, signedness, store flag, write data, crossing flag, error flag.
- **Memory port rule (all states).**
  - `mem_read_addr` = the current word pointer register.
  - `mem_write_addr` = `mem_read_addr`.
  - `mem_write_data` = `mem_read_data`, except during store commit.
  - During store commit, `mem_write_data` = `mem_read_data` with the addressed bytes replaced.
- **Word pointer register.**
  - Loaded with word0 on accept, and with word1 on ACC0 → ACC1.
  - Otherwise it holds its value.
- **States.**
  - IDLE: `req_ready=1`. On accept go to ACC0 (for an error request as well; no write occurs).
  - ACC0: a load latches the word0 bytes into the assembly buffer; a store commits the word0 bytes. Go to ACC1 if crossing and not an error, else go to RESP.
  - ACC1: a load latches the word1 bytes; a store commits the word1 bytes. Go to RESP.
  - RESP: `resp_valid=1`. Go to IDLE.
- **Load extension.**
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW is unmodified.
- **`resp_rdata`** is registered and valid only while `resp_valid` is high; otherwise it holds 0.

## Timing

- Request accepted at edge E0.
- Non-crossing access: ACC0 is the cycle after E0 and `resp_valid` is high in the cycle after E0+1.
- Accept-to-`resp_valid`: 2 cycles non-crossing, 3 cycles crossing.
- Back-to-back throughput: one request per 3 cycles non-crossing, 4 cycles crossing.
- Store data is in memory at the edge that ends ACC0 (and ACC1 for a crossing store), before `resp_valid` rises.
- **Reset values:**
  - State IDLE, `req_ready=1`.
  - `resp_valid=0`, `resp_rdata=0`, `resp_err=0`.
  - Word pointer 0.
  - Therefore `mem_*_addr=0` and `mem_write_data=mem_read_data`.
- **Reset mid-operation:**
  - Asynchronous abort to IDLE; no response is issued.
  - A crossing store reset after ACC0 leaves word0 updated and word1 unchanged. This is permitted.
- `req_valid` outside IDLE is ignored; the request is not accepted and not queued.

## Test plan

- SW 0x010 data 0xDEADBEEF, then LW 0x010 → `resp_rdata` 0xDEADBEEF, `resp_valid` 2 cycles after accept, `resp_err`=0.
- SB 0x013 data 0x000000AA over 0xDEADBEEF, then:
  - LW 0x010 → 0xAAADBEEF
  - LB 0x013 → 0xFFFFFFAA
  - LBU 0x013 → 0x000000AA
  - LH 0x012 → 0xFFFFAAAD
- Crossing store/load:
  - After zeroing words 0x01C and 0x020: SW 0x01E data 0x11223344 → word 0x01C = 0x33440000, word 0x020 = 0x00001122.
  - LW 0x01E → 0x11223344, `resp_valid` 3 cycles after accept.
- Wrap-around (`ADDR_WIDTH`=12): SB 0x3FFF data 0x80 and SB 0x0000 data 0x7F, then LH 0x3FFF → 0x00007F80 via words 0xFFF and 0x000.
- Idle integrity and illegal funct3:
  - 20 idle cycles, then LW of a preloaded word → unchanged value.
  - Store with funct3 011 → `resp_err`=1, `resp_rdata`=0, target word unchanged.
- Reset asserted during ACC1 of a crossing SW:
  - Immediately `resp_valid`=0 and `req_ready`=1.
  - Word0 is updated, word1 is untouched.
  - After deassert, the next LW completes normally.
